approx_prod_accum: RTL
======================

Name: approx_prod_accum

Overview:
- Downstream consumer of the 4x4 approximate multiplier stage in the Strassen datapath.
- Accepts a stream of unsigned 8-bit approximate products over a valid/ready handshake and accumulates each vector (delimited by `prod_last`) into a saturating sum.
- Emits one result per vector, with the term count and an overflow flag, on a valid/ready output port.
- The result feeds the Strassen partial-sum combine logic.

Parameters:
- PROD_W, 8, width of each incoming product (4x4 multiplier output width).
- ACC_W, 16, accumulator and result width; must be >= PROD_W.
- CNT_W, 8, term-counter width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- prod_valid  input  1  product beat present.
- prod_ready  output  1  block can accept a beat this cycle.
- prod_data  input  PROD_W  unsigned approximate product.
- prod_last  input  1  beat is the final term of the current vector.
- sum_valid  output  1  result held on the sum_* outputs.
- sum_ready  input  1  downstream accepts the result.
- sum_data  output  ACC_W  saturated unsigned sum of the vector.
- sum_count  output  CNT_W  number of terms in the vector, saturating.
- sum_ovf  output  1  sticky flag: the accumulator saturated during this vector.

Behaviour:
- Interface: one clock `clk`; asynchronous active-high reset `rst`.
- Reset, asynchronous and immediate:
  - Outputs: sum_valid=0, sum_data=0, sum_count=0, sum_ovf=0.
  - Internals: acc=0, cnt=0, ovf=0, state=ACCUM.
  - Reset mid-vector discards the partial sum; no result is emitted for it.
- States:
  - ACCUM: no result pending.
  - HOLD: result pending, sum_valid=1.
- Handshakes:
  - prod_ready = !sum_valid || sum_ready. Purely combinational from registered state and sum_ready; never depends on prod_valid.
  - A beat is accepted when prod_valid && prod_ready.
  - A result is consumed when sum_valid && sum_ready.
- Accepted beat with prod_last=0:
  - acc <= sat(acc + zext(prod_data)).
  - cnt <= sat(cnt+1).
  - ovf <= ovf | carry-out.
- Accepted beat with prod_last=1:
  - sum_data <= sat(acc + zext(prod_data)).
  - sum_count <= sat(cnt+1).
  - sum_ovf <= ovf | carry-out.
  - sum_valid <= 1; acc, cnt and ovf clear to 0; state becomes HOLD.
- Latency: sum_valid rises the cycle after the last beat is accepted.
- HOLD with sum_ready=0: all sum_* outputs stay stable and prod_ready=0. The next vector's beats stall; none are lost.
- HOLD with sum_ready=1:
  - The result is consumed; sum_valid <= 0 unless a last beat is accepted in the same cycle.
  - A simultaneous accepted last beat reloads sum_* with the new result and keeps sum_valid=1. Back-to-back single-beat vectors sustain one result per cycle.
  - A simultaneous non-last beat accumulates normally.
- Saturation:
  - sum = acc + prod_data.
  - sum >= 2^ACC_W gives all-ones and sets ovf.
  - Further terms keep the accumulator at all-ones.
  - cnt saturates at 2^CNT_W-1; counter saturation does not set ovf.
- A single-beat vector (prod_last on the first beat) yields sum_data=prod_data, sum_count=1.
- Empty vectors are impossible; every result covers at least one beat.
- sum_data and sum_count come straight from registers; no combinational path from prod_* to sum_*.

Decomposition:
- Shared package approx_mm_pkg:
  - PROD_W and ACC_W default constants.
  - Accumulator state enum (ACCUM, HOLD).
  - Function sat_add(a, b) returning {ovf, sum}.
- One natural sub-module: approx_sat_add, a combinational saturating ACC_W adder with carry-out flag. Instantiated once for the accumulator path.
- Keep the counter inline.

Test Plan:
- Reset then vector 15, 6, 9 (last on 9), sum_ready=1 → one cycle after the last beat: sum_valid=1, sum_data=30, sum_count=3, sum_ovf=0. prod_ready stays 1 throughout.
- Single-beat vectors 225, then 4, then 1 on consecutive cycles, sum_ready=1 → sum_data sequence 225, 4, 1 on consecutive cycles; sum_count=1 each; no bubbles.
- ACC_W=9, vector 255, 255, 10 (last) → sum_data=511, sum_ovf=1, sum_count=3. The next vector 7 (last) gives sum_data=7, sum_ovf=0.
- Result pending with sum_ready=0 for 5 cycles while prod_valid=1 with 3, 3 (last) → prod_ready=0 and sum_* stable for 5 cycles. After sum_ready rises, 3, 3 is accepted and the next result is 6, count 2.
- Assert rst mid-vector after beats 100 and 50, then send vector 8 (last) → no result for the aborted vector; the next result is 8, count 1, ovf 0. Outputs read 0 during reset.
- CNT_W=2 with a 5-term vector of 1s → sum_data=5, sum_count=3 (saturated), sum_ovf=0.

Source files
------------

// File: rtl/approx_mm_pkg.sv
// approx_mm_pkg: shared constants, accumulator states and saturating add for the approximate-multiply datapath
package approx_mm_pkg;
  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
  typedef enum logic {ACCUM, HOLD} acc_state_t;
  // Returns {ovf, sum}; the sum is clamped to all-ones of width w (w <= 32)
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
    logic [31:0] m;
    logic [32:0] s;
    m = (w >= 32) ? 32'hffff_ffff : (32'd1 << w) - 32'd1;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, m}) ? {1'b1, m} : s;
  endfunction
endpackage

// File: rtl/approx_sat_add.sv
// approx_sat_add: combinational saturating ACC_W adder of a zero-extended PROD_W term with carry-out flag
module approx_sat_add
  import approx_mm_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  logic [32:0] r;
  assign r = sat_add(32'(a), 32'(b), ACC_W);
  assign sum = r[ACC_W-1:0];
  // Bits above ACC_W are always zero after clamping; folding them in keeps every bit of r consumed
  assign ovf = r[32] | (|(r[31:0] >> ACC_W));
endmodule

// File: rtl/approx_prod_accum.sv
// approx_prod_accum: accumulates a stream of approximate products per vector into a saturating sum
module approx_prod_accum
  import approx_mm_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_ovf
);
  acc_state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic ovf, carry, beat;
  approx_sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .a(acc),
    .b(prod_data),
    .sum(acc_n),
    .ovf(carry)
  );
  assign sum_valid = state == HOLD;
  assign prod_ready = !sum_valid || sum_ready;
  assign beat = prod_valid && prod_ready;
  assign cnt_n = &cnt ? cnt : cnt + 1'b1;
  always_comb begin
    state_n = (beat && prod_last) ? HOLD : (sum_valid && sum_ready) ? ACCUM : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      sum_data <= '0;
      sum_count <= '0;
      sum_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (beat && prod_last) begin
        sum_data <= acc_n;
        sum_count <= cnt_n;
        sum_ovf <= ovf | carry;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (beat) begin
        acc <= acc_n;
        cnt <= cnt_n;
        ovf <= ovf | carry;
      end
    end
  end
endmodule
